// File: rtl/frame_sync_avalon_if.sv
// ---------------------------------------------------------------------------
// frame_sync_avalon_if
// Purpose : Avalon-MM bus bundle between the NIOS II (master) and the
//           frame-sync timing block (slave).
// Signals :
//   AVL_CS         chip select
//   AVL_READ       read strobe, qualified by AVL_CS
//   AVL_WRITE      write strobe, qualified by AVL_CS
//   AVL_ADDR       2-bit word address
//   AVL_WRITEDATA  32-bit write data
//   AVL_READDATA   32-bit read data, returned one cycle after the read
// ---------------------------------------------------------------------------
interface frame_sync_avalon_if;
  logic        AVL_CS;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic [1:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;

  modport master (
    output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_READDATA
  );

  modport slave (
    input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA,
    output AVL_READDATA
  );
endinterface

// File: rtl/frame_sync_avalon.sv
// ---------------------------------------------------------------------------
// frame_sync_avalon
// Purpose : Display-timing slave for the NIOS II. Detects the start of VGA
//           vertical sync, counts frames, keeps a sticky frame flag / overrun
//           flag with a level IRQ, and defers software-requested ball-buffer
//           swaps to the next vsync so the renderer never swaps mid-frame.
// Ports   :
//   Clk          system clock, all logic on posedge
//   Reset_n      synchronous active-low reset
//   avl          Avalon-MM slave bus (see frame_sync_avalon_if)
//   VGA_VS       active-low vertical sync, asynchronous to Clk
//   SWAP_PULSE   one-cycle pulse telling the renderer to swap buffers
//   FRONT_SEL    index of the current front ball buffer
//   IRQ          level interrupt = IRQ_EN & FRAME_FLAG
// Register map:
//   0 STATUS   R : [0]FRAME_FLAG [1]COMMIT_PENDING [2]FRONT_SEL [3]OVERRUN
//                  [31:16]frame_count[15:0];  W1C on bits 0 and 3
//   1 CONTROL  RW: [0]IRQ_EN
//   2 COMMIT   W : any write requests a swap; R: [15:0] completed swaps
//   3 FRAMECNT R : frame_count zero-extended
// ---------------------------------------------------------------------------
module frame_sync_avalon #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  frame_sync_avalon_if.slave    avl,
  input  logic                  VGA_VS,
  output logic                  SWAP_PULSE,
  output logic                  FRONT_SEL,
  output logic                  IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // ---------------------------------------------------------------- vsync
  logic [SYNC_STAGES-1:0] r_vs_sync;
  logic                   r_vs_hist;
  logic                   w_vs_fall;

  // Resetting the chain and history to 0 means a high VGA_VS after reset
  // can never look like a falling edge.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_vs_sync <= '0;
      r_vs_hist <= 1'b0;
    end else begin
      r_vs_sync <= {r_vs_sync[SYNC_STAGES-2:0], VGA_VS};
      r_vs_hist <= r_vs_sync[SYNC_STAGES-1];
    end
  end

  assign w_vs_fall = r_vs_hist & ~r_vs_sync[SYNC_STAGES-1];

  // ------------------------------------------------------------ bus decode
  logic w_wr;
  logic w_rd;
  logic w_wr_status;
  logic w_wr_control;
  logic w_wr_commit;

  assign w_wr         = avl.AVL_CS & avl.AVL_WRITE;
  assign w_rd         = avl.AVL_CS & avl.AVL_READ;
  assign w_wr_status  = w_wr && (avl.AVL_ADDR == 2'd0);
  assign w_wr_control = w_wr && (avl.AVL_ADDR == 2'd1);
  assign w_wr_commit  = w_wr && (avl.AVL_ADDR == 2'd2);

  logic w_unused_wdata;
  assign w_unused_wdata = ^{avl.AVL_WRITEDATA[31:4], avl.AVL_WRITEDATA[2:1]};

  // ------------------------------------------------------- frame tracking
  logic [CNT_W-1:0] r_frame_count;
  logic             r_frame_flag;
  logic             r_overrun;
  logic             r_irq_en;

  // A vsync edge in the same cycle as a W1C must leave the flag set, so
  // the set term is tested first.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_frame_count <= '0;
      r_frame_flag  <= 1'b0;
      r_overrun     <= 1'b0;
      r_irq_en      <= 1'b0;
    end else begin
      if (w_vs_fall) begin
        r_frame_count <= r_frame_count + CNT_ONE;
      end

      if (w_vs_fall) begin
        r_frame_flag <= 1'b1;
      end else if (w_wr_status && avl.AVL_WRITEDATA[0]) begin
        r_frame_flag <= 1'b0;
      end

      // Overrun only sets when the previous frame was never acknowledged.
      if (w_vs_fall && r_frame_flag) begin
        r_overrun <= 1'b1;
      end else if (w_wr_status && avl.AVL_WRITEDATA[3]) begin
        r_overrun <= 1'b0;
      end

      if (w_wr_control) begin
        r_irq_en <= avl.AVL_WRITEDATA[0];
      end
    end
  end

  assign IRQ = r_irq_en & r_frame_flag;

  // ------------------------------------------------------------ commit FSM
  state_t      r_state;
  state_t      w_state_next;
  logic        r_front_sel;
  logic [15:0] r_swap_cnt;
  logic        w_swap_entry;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A commit landing on the vsync cycle in IDLE only arms the request; the
  // swap waits for the following vsync so the frame it was meant for has
  // actually been rendered.
  always_comb begin
    w_state_next = r_state;
    w_swap_entry = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_commit) begin
          w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_vs_fall) begin
          w_state_next = ST_SWAP;
          w_swap_entry = 1'b1;
        end
      end
      ST_SWAP: begin
        w_state_next = w_wr_commit ? ST_PENDING : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_front_sel <= 1'b0;
      r_swap_cnt  <= 16'd0;
    end else if (w_swap_entry) begin
      r_front_sel <= ~r_front_sel;
      r_swap_cnt  <= r_swap_cnt + 16'd1;
    end
  end

  assign SWAP_PULSE = (r_state == ST_SWAP);
  assign FRONT_SEL  = r_front_sel;

  // -------------------------------------------------------------- readback
  logic [31:0] w_fc32;
  logic [31:0] w_rdata;
  logic [31:0] r_readdata;

  always_comb begin
    w_fc32              = '0;
    w_fc32[CNT_W-1:0]   = r_frame_count;
  end

  always_comb begin
    w_rdata = '0;
    case (avl.AVL_ADDR)
      2'd0: w_rdata = {w_fc32[15:0], 12'd0, r_overrun, r_front_sel,
                       (r_state == ST_PENDING), r_frame_flag};
      2'd1: w_rdata = {31'd0, r_irq_en};
      2'd2: w_rdata = {16'd0, r_swap_cnt};
      2'd3: w_rdata = w_fc32;
      default: w_rdata = '0;
    endcase
  end

  // Read data is captured from pre-edge register values, so a write in
  // the same cycle is not visible until the next read.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      r_readdata <= w_rdata;
    end
  end

  assign avl.AVL_READDATA = r_readdata;

endmodule

// File: tb/tb_frame_sync_avalon.sv
// ---------------------------------------------------------------------------
// tb_frame_sync_avalon
// Purpose : Directed self-checking bench for frame_sync_avalon. Drives the
//           Avalon bus through the interface, generates VGA_VS pulses and
//           checks outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_frame_sync_avalon;

  logic clk;
  logic rst_n;
  logic vga_vs;
  logic swap_pulse;
  logic front_sel;
  logic irq;

  int n_checks;
  int n_errors;

  frame_sync_avalon_if bus ();

  frame_sync_avalon #(
    .SYNC_STAGES (2),
    .CNT_W       (32)
  ) dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .avl        (bus),
    .VGA_VS     (vga_vs),
    .SWAP_PULSE (swap_pulse),
    .FRONT_SEL  (front_sel),
    .IRQ        (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write is sampled on the second posedge seen by this task.
  task automatic avl_write(input logic [1:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.AVL_CS        = 1'b1;
    bus.AVL_WRITE     = 1'b1;
    bus.AVL_ADDR      = addr;
    bus.AVL_WRITEDATA = data;
    @(posedge clk); #1;
    bus.AVL_CS        = 1'b0;
    bus.AVL_WRITE     = 1'b0;
    bus.AVL_WRITEDATA = '0;
  endtask

  task automatic avl_read(input logic [1:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    bus.AVL_CS   = 1'b1;
    bus.AVL_READ = 1'b1;
    bus.AVL_ADDR = addr;
    @(posedge clk); #1;
    bus.AVL_CS   = 1'b0;
    bus.AVL_READ = 1'b0;
    @(posedge clk); #1;
    data = bus.AVL_READDATA;
  endtask

  // Drives VGA_VS low just after an edge P; the next edges are E0, E1, E2.
  task automatic vs_low();
    @(posedge clk); #1;
    vga_vs = 1'b0;
  endtask

  task automatic vs_high();
    @(posedge clk); #1;
    vga_vs = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // Full vsync pulse followed by a quiet gap.
  task automatic vs_pulse(input int gap);
    vs_low();
    repeat (4) @(posedge clk);
    vs_high();
    repeat (gap) @(posedge clk);
  endtask

  logic [31:0] rd;

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    rst_n             = 1'b0;
    vga_vs            = 1'b1;
    bus.AVL_CS        = 1'b0;
    bus.AVL_READ      = 1'b0;
    bus.AVL_WRITE     = 1'b0;
    bus.AVL_ADDR      = 2'd0;
    bus.AVL_WRITEDATA = '0;

    // ---- reset with VGA_VS toggling
    @(posedge clk); #1;
    vga_vs = 1'b0;
    @(negedge clk);
    check("rst1_swap", {31'd0, swap_pulse}, 32'd0);
    check("rst1_front", {31'd0, front_sel}, 32'd0);
    check("rst1_irq", {31'd0, irq}, 32'd0);
    check("rst1_rdata", bus.AVL_READDATA, 32'd0);
    @(posedge clk); #1;
    vga_vs = 1'b1;
    @(negedge clk);
    check("rst2_swap", {31'd0, swap_pulse}, 32'd0);
    check("rst2_front", {31'd0, front_sel}, 32'd0);
    check("rst2_irq", {31'd0, irq}, 32'd0);
    check("rst2_rdata", bus.AVL_READDATA, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    avl_read(2'd3, rd); check("rst_framecnt", rd, 32'd0);
    avl_read(2'd0, rd); check("rst_status", rd, 32'd0);

    // ---- three vsyncs 800 clocks apart, no acknowledgement
    vs_pulse(800);
    vs_pulse(800);
    vs_pulse(800);
    avl_read(2'd3, rd); check("3vs_framecnt", rd, 32'd3);
    avl_read(2'd0, rd); check("3vs_status", rd, 32'h0003_0009);
    check("3vs_irq_disabled", {31'd0, irq}, 32'd0);

    // ---- W1C both flags, enable IRQ, check IRQ timing
    avl_write(2'd0, 32'h0000_0009);
    avl_read(2'd0, rd); check("w1c_status", rd, 32'h0003_0000);
    avl_write(2'd1, 32'h0000_0001);
    avl_read(2'd1, rd); check("ctrl_read", rd, 32'd1);
    vs_low();
    @(posedge clk); // E0
    @(posedge clk); // E1
    @(negedge clk);
    check("irq_before_e2", {31'd0, irq}, 32'd0);
    @(posedge clk); // E2
    @(negedge clk);
    check("irq_after_e2", {31'd0, irq}, 32'd1);
    vs_high();
    avl_write(2'd0, 32'h0000_0001);
    @(negedge clk);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // ---- two commits coalesce into one swap at the next vsync (count=4)
    avl_write(2'd2, 32'h0);
    avl_write(2'd2, 32'h0);
    avl_read(2'd0, rd); check("pending_status", rd, 32'h0004_0002);
    vs_low();
    @(posedge clk); // E0
    @(posedge clk); // E1
    @(negedge clk);
    check("swap_before_e2", {31'd0, swap_pulse}, 32'd0);
    check("front_before_e2", {31'd0, front_sel}, 32'd0);
    @(posedge clk); // E2
    @(negedge clk);
    check("swap_at_e2", {31'd0, swap_pulse}, 32'd1);
    check("front_at_e2", {31'd0, front_sel}, 32'd1);
    @(posedge clk); // E3
    @(negedge clk);
    check("swap_after_e3", {31'd0, swap_pulse}, 32'd0);
    check("front_after_e3", {31'd0, front_sel}, 32'd1);
    vs_high();
    avl_read(2'd2, rd); check("swapcnt_1", rd, 32'd1);
    check("irq_new_frame", {31'd0, irq}, 32'd1);

    // ---- commit on the vs_fall cycle in IDLE: no swap now (count=6)
    vs_low();
    @(posedge clk); // E0
    @(posedge clk); #1; // after E1: vs_fall high this cycle
    bus.AVL_CS = 1'b1; bus.AVL_WRITE = 1'b1; bus.AVL_ADDR = 2'd2;
    @(posedge clk); #1; // E2
    bus.AVL_CS = 1'b0; bus.AVL_WRITE = 1'b0;
    @(negedge clk);
    check("coinc_swap_e2", {31'd0, swap_pulse}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("coinc_swap_e3", {31'd0, swap_pulse}, 32'd0);
    check("coinc_front", {31'd0, front_sel}, 32'd1);
    vs_high();
    avl_read(2'd0, rd); check("coinc_status", rd, 32'h0006_000F);
    // next vsync performs the deferred swap (count=7)
    vs_low();
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); // E2
    @(negedge clk);
    check("deferred_swap", {31'd0, swap_pulse}, 32'd1);
    check("deferred_front", {31'd0, front_sel}, 32'd0);
    vs_high();
    avl_read(2'd2, rd); check("swapcnt_2", rd, 32'd2);

    // ---- W1C on the vs_fall cycle: set wins (count=8)
    avl_write(2'd0, 32'h0000_0009);
    avl_read(2'd0, rd); check("pre_race_status", rd, 32'h0007_0000);
    vs_low();
    @(posedge clk);
    @(posedge clk); #1;
    bus.AVL_CS = 1'b1; bus.AVL_WRITE = 1'b1; bus.AVL_ADDR = 2'd0;
    bus.AVL_WRITEDATA = 32'h0000_0001;
    @(posedge clk); #1;
    bus.AVL_CS = 1'b0; bus.AVL_WRITE = 1'b0; bus.AVL_WRITEDATA = '0;
    vs_high();
    avl_read(2'd0, rd); check("race_status", rd, 32'h0008_0001);
    check("race_irq", {31'd0, irq}, 32'd1);

    // ---- swap once more, then reset while PENDING (count=9)
    avl_write(2'd2, 32'h0);
    vs_pulse(10);
    avl_write(2'd2, 32'h0);
    avl_read(2'd0, rd); check("prereset_status", rd, 32'h0009_000F);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_front", {31'd0, front_sel}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_swap", {31'd0, swap_pulse}, 32'd0);
    avl_read(2'd0, rd); check("reset_status", rd, 32'd0);
    vs_low();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_swap_after_reset", {31'd0, swap_pulse}, 32'd0);
    end
    vs_high();
    avl_read(2'd3, rd); check("reset_framecnt", rd, 32'd1);
    avl_read(2'd2, rd); check("reset_swapcnt", rd, 32'd0);
    check("reset_front_final", {31'd0, front_sel}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
